ls299_pixel_serializer: RTL and testbench



---
 rtl/ls299_pixel_serializer.sv | 76 +++++++
 tb/tb_ls299_pixel_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ls299_pixel_serializer.sv
// Bitplane parallel-in/serial-out pixel shifter with a line-position counter.
// Loads PLANES words every WIDTH pixels and shifts left (or right when flipped).
module ls299_pixel_serializer #(
  parameter int unsigned PLANES = 2,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      n_clr,
  input  logic                      pix_ce,
  input  logic                      n_sync,
  input  logic [PLANES*WIDTH-1:0]   d_plane,
  input  logic                      d_valid,
  input  logic                      flip,
  input  logic                      underrun_clr,
  output logic [PLANES-1:0]         pix,
  output logic [CW-1:0]             pix_cnt,
  output logic                      ld_done,
  output logic                      underrun
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [PLANES-1:0][WIDTH-1:0] sr;
  logic [CW-1:0]                cnt;
  logic                         flip_l;
  logic                         load_c;

  // A load happens on the last pixel of a word or on a line restart.
  assign load_c  = pix_ce & ((cnt == CNT_LAST) | ~n_sync);
  assign pix_cnt = cnt;

  // Shift registers, counter and latched flip direction.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      sr     <= '0;
      cnt    <= CNT_LAST;
      flip_l <= 1'b0;
    end else if (load_c) begin
      sr     <= d_valid ? d_plane : '0;
      flip_l <= flip;
      cnt    <= '0;
    end else if (pix_ce) begin
      for (int p = 0; p < int'(PLANES); p++) begin
        sr[p] <= flip_l ? {1'b0, sr[p][WIDTH-1:1]} : {sr[p][WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
    end else if (!n_sync) begin
      cnt <= CNT_LAST;
    end
  end

  // Load strobe and sticky underrun flag; a new underrun beats a clear.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      ld_done  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      ld_done <= load_c;
      if (load_c && !d_valid) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // Output pixel is the bit about to leave the register in the current direction.
  always_comb begin
    pix = '0;
    for (int p = 0; p < int'(PLANES); p++) begin
      pix[p] = flip_l ? sr[p][0] : sr[p][WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ls299_pixel_serializer.sv
// Directed bench for ls299_pixel_serializer (PLANES=2, WIDTH=8).
module tb_ls299_pixel_serializer;

  logic        clk;
  logic        n_clr;
  logic        pix_ce;
  logic        n_sync;
  logic [15:0] d_plane;
  logic        d_valid;
  logic        flip;
  logic        underrun_clr;
  logic [1:0]  pix;
  logic [2:0]  pix_cnt;
  logic        ld_done;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  // plane0 = 8'hA5, plane1 = 8'h0F; pix = {plane1, plane0}
  localparam logic [1:0] EXP_N [8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
  localparam logic [1:0] EXP_F [8] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};

  ls299_pixel_serializer #(.PLANES(2), .WIDTH(8)) dut (
    .clk          (clk),
    .n_clr        (n_clr),
    .pix_ce       (pix_ce),
    .n_sync       (n_sync),
    .d_plane      (d_plane),
    .d_valid      (d_valid),
    .flip         (flip),
    .underrun_clr (underrun_clr),
    .pix          (pix),
    .pix_cnt      (pix_cnt),
    .ld_done      (ld_done),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_clr = 1'b0; pix_ce = 1'b0; n_sync = 1'b1; d_plane = 16'h0FA5;
    d_valid = 1'b1; flip = 1'b0; underrun_clr = 1'b0;
    step(); step();
    checks++; if (pix !== 2'b00) begin errors++; $display("FAIL reset_pix: got %b expected 00", pix); end
    checks++; if (pix_cnt !== 3'd7) begin errors++; $display("FAIL reset_cnt: got %0d expected 7", pix_cnt); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_ld_done: got %b expected 0", ld_done); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    n_clr = 1'b1;
    step();
    checks++; if (pix_cnt !== 3'd7) begin errors++; $display("FAIL idle_hold_cnt: got %0d expected 7", pix_cnt); end
  endtask

  task automatic test_normal();
    pix_ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (pix !== EXP_N[i]) begin errors++; $display("FAIL normal_pix[%0d]: got %b expected %b", i, pix, EXP_N[i]); end
      checks++; if (pix_cnt !== 3'(i)) begin errors++; $display("FAIL normal_cnt[%0d]: got %0d expected %0d", i, pix_cnt, i); end
      checks++; if (ld_done !== (i == 0)) begin errors++; $display("FAIL normal_ld_done[%0d]: got %b expected %b", i, ld_done, i == 0); end
    end
  endtask

  task automatic test_flip();
    flip = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) flip = 1'b0;  // must not affect the word already loaded
      checks++; if (pix !== EXP_F[i]) begin errors++; $display("FAIL flip_pix[%0d]: got %b expected %b", i, pix, EXP_F[i]); end
      checks++; if (pix_cnt !== 3'(i)) begin errors++; $display("FAIL flip_cnt[%0d]: got %0d expected %0d", i, pix_cnt, i); end
      checks++; if (ld_done !== (i == 0)) begin errors++; $display("FAIL flip_ld_done[%0d]: got %b expected %b", i, ld_done, i == 0); end
    end
  endtask

  task automatic test_ce_toggle();
    for (int k = 0; k < 16; k++) begin
      pix_ce = (k % 2 == 0);
      step();
      checks++; if (pix !== EXP_N[k/2]) begin errors++; $display("FAIL toggle_pix[%0d]: got %b expected %b", k, pix, EXP_N[k/2]); end
      checks++; if (pix_cnt !== 3'(k/2)) begin errors++; $display("FAIL toggle_cnt[%0d]: got %0d expected %0d", k, pix_cnt, k/2); end
      checks++; if (ld_done !== (k == 0)) begin errors++; $display("FAIL toggle_ld_done[%0d]: got %b expected %b", k, ld_done, k == 0); end
    end
  endtask

  task automatic test_sync();
    pix_ce = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (pix_cnt !== 3'd3) begin errors++; $display("FAIL sync_pre_cnt: got %0d expected 3", pix_cnt); end
    d_plane = 16'hFF00;
    n_sync = 1'b0;
    step();
    n_sync = 1'b1;
    checks++; if (pix_cnt !== 3'd0) begin errors++; $display("FAIL sync_cnt: got %0d expected 0", pix_cnt); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL sync_ld_done: got %b expected 1", ld_done); end
    checks++; if (pix !== 2'b10) begin errors++; $display("FAIL sync_pix: got %b expected 10", pix); end
    step();
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL sync_ld_done_fall: got %b expected 0", ld_done); end
    step(); step();
    pix_ce = 1'b0;
    n_sync = 1'b0;
    step();
    n_sync = 1'b1;
    checks++; if (pix_cnt !== 3'd7) begin errors++; $display("FAIL sync_idle_cnt: got %0d expected 7", pix_cnt); end
    checks++; if (pix !== 2'b10) begin errors++; $display("FAIL sync_idle_pix: got %b expected 10", pix); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL sync_idle_ld_done: got %b expected 0", ld_done); end
    step();
    checks++; if (pix_cnt !== 3'd7) begin errors++; $display("FAIL sync_hold_cnt: got %0d expected 7", pix_cnt); end
    d_plane = 16'h0FA5;
    pix_ce = 1'b1;
    step();
    checks++; if (pix_cnt !== 3'd0) begin errors++; $display("FAIL sync_next_cnt: got %0d expected 0", pix_cnt); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL sync_next_ld_done: got %b expected 1", ld_done); end
    checks++; if (pix !== 2'b01) begin errors++; $display("FAIL sync_next_pix: got %b expected 01", pix); end
    n_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (ld_done !== 1'b1 || pix_cnt !== 3'd0 || pix !== 2'b01) begin
        errors++; $display("FAIL sync_hold_low[%0d]: got ld=%b cnt=%0d pix=%b expected ld=1 cnt=0 pix=01", i, ld_done, pix_cnt, pix);
      end
    end
    n_sync = 1'b1;
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 7; i++) step();
    d_valid = 1'b0;
    step();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL underrun_ld_done: got %b expected 1", ld_done); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      checks++; if (pix !== 2'b00) begin errors++; $display("FAIL underrun_pix[%0d]: got %b expected 00", i, pix); end
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky[%0d]: got %b expected 1", i, underrun); end
    end
    underrun_clr = 1'b1;
    step();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set_priority: got %b expected 1", underrun); end
    underrun_clr = 1'b0;
    d_valid = 1'b1;
    step();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_hold: got %b expected 1", underrun); end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
    checks++; if (pix_cnt !== 3'd2) begin errors++; $display("FAIL underrun_cnt: got %0d expected 2", pix_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 5; i++) step();
    checks++; if (pix_cnt !== 3'd5 || pix !== 2'b11) begin
      errors++; $display("FAIL midreset_pre: got cnt=%0d pix=%b expected cnt=5 pix=11", pix_cnt, pix);
    end
    #2;
    n_clr = 1'b0;
    #1;
    checks++; if (pix !== 2'b00) begin errors++; $display("FAIL midreset_pix: got %b expected 00", pix); end
    checks++; if (pix_cnt !== 3'd7) begin errors++; $display("FAIL midreset_cnt: got %0d expected 7", pix_cnt); end
    checks++; if (ld_done !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: got ld=%b ur=%b expected 0 0", ld_done, underrun);
    end
    step();
    n_clr = 1'b1;
    d_plane = 16'hFF00;
    step();
    checks++; if (pix_cnt !== 3'd0 || ld_done !== 1'b1 || pix !== 2'b10) begin
      errors++; $display("FAIL midreset_reload: got cnt=%0d ld=%b pix=%b expected cnt=0 ld=1 pix=10", pix_cnt, ld_done, pix);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_flip();
    test_ce_toggle();
    test_sync();
    test_underrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
